// File: rtl/dcache_if.sv
// dcache_if: pipeline request/response and backing-SRAM signals of the data cache.
interface dcache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ack;
  modport master (
    output rd_en, wr_en, addr, wdata, sram_rdata, sram_ack,
    input  rdata, ready, sram_req, sram_we, sram_addr, sram_wdata
  );
  modport slave (
    input  rd_en, wr_en, addr, wdata, sram_rdata, sram_ack,
    output rdata, ready, sram_req, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: set-associative write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2
) (
  input logic clk,
  input logic rst,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int SB = $clog2(SETS);
  localparam int TW = ADDR_W - 2 - OW - SB;
  localparam int CW = OW > 0 ? OW : 1;
  localparam int SW = SB > 0 ? SB : 1;
  localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] a_r, la, wa;
  logic [DATA_W-1:0] d_r;
  logic [SETS-1:0]   vld [WAYS];
  logic [TW-1:0]     tag_m [WAYS][SETS];
  logic [DATA_W-1:0] dat_m [WAYS][SETS][LINE_WORDS];
  logic [DATA_W-1:0] lbuf [LINE_WORDS];
  logic [CW-1:0]     off;
  logic [SW-1:0]     set;
  logic [TW-1:0]     tag;
  logic [VW-1:0]     hw, iw, vw, ptr_cur;
  logic              hit, inv, rd, wr, ld_hit, fill_done, wr_done;

  // Lookups use the live address while idle and the captured request otherwise.
  assign la  = state == IDLE ? bus.addr : a_r;
  assign wa  = la >> 2;
  assign off = CW'(wa) & CW'(LINE_WORDS - 1);
  assign set = SW'(wa >> OW) & SW'(SETS - 1);
  assign tag = TW'(wa >> (OW + SB));

  always_comb begin
    hit = 1'b0;
    hw  = '0;
    inv = 1'b0;
    iw  = '0;
    for (int w = 0; w < WAYS; w++)
      if (vld[w][set] && tag_m[w][set] == tag) begin
        hit = 1'b1;
        hw  = VW'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!vld[w][set]) begin
        inv = 1'b1;
        iw  = VW'(w);
      end
  end

  generate
    if (WAYS > 1) begin : g_ptr
      logic [VW-1:0] ptr [SETS];
      assign ptr_cur = ptr[set];
      always_ff @(posedge clk)
        if (rst)
          for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        else if (fill_done)
          ptr[set] <= ptr[set] + 1'b1;
    end else begin : g_noptr
      assign ptr_cur = '0;
    end
  endgenerate

  assign vw        = inv ? iw : ptr_cur;
  assign wr        = bus.wr_en;
  assign rd        = bus.rd_en & ~bus.wr_en;
  assign ld_hit    = state == IDLE && rd && hit;
  assign fill_done = state == FILL && bus.sram_ack && cnt == CW'(LINE_WORDS - 1);
  assign wr_done   = state == WRITE && bus.sram_ack;

  assign bus.ready      = state == IDLE ? !(wr || (rd && !hit)) : wr_done;
  assign bus.rdata      = ld_hit ? dat_m[hw][set][off] : '0;
  assign bus.sram_req   = state != IDLE;
  assign bus.sram_we    = state == WRITE;
  assign bus.sram_addr  = state == FILL  ? (a_r & ~ADDR_W'(LINE_WORDS * 4 - 1)) | (ADDR_W'(cnt) << 2) :
                          state == WRITE ? a_r & ~ADDR_W'(3) : '0;
  assign bus.sram_wdata = state == WRITE ? d_r : '0;

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_r   <= '0;
      d_r   <= '0;
      for (int w = 0; w < WAYS; w++) vld[w] <= '0;
    end else if (state == IDLE) begin
      if (wr) begin
        state <= WRITE;
        a_r   <= bus.addr;
        d_r   <= bus.wdata;
      end else if (rd && !hit) begin
        state <= FILL;
        cnt   <= '0;
        a_r   <= bus.addr;
      end
    end else if (state == FILL) begin
      if (bus.sram_ack) cnt <= cnt + 1'b1;
      if (fill_done) begin
        state        <= IDLE;
        cnt          <= '0;
        vld[vw][set] <= 1'b1;
      end
    end else if (wr_done)
      state <= IDLE;

  always_ff @(posedge clk) begin
    if (state == FILL && bus.sram_ack) lbuf[cnt] <= bus.sram_rdata;
    if (fill_done) begin
      tag_m[vw][set] <= tag;
      for (int i = 0; i < LINE_WORDS; i++)
        dat_m[vw][set][i] <= CW'(i) == cnt ? bus.sram_rdata : lbuf[i];
    end
    if (wr_done && hit) dat_m[hw][set][off] <= d_r;
  end

`ifdef DCACHE_STATS_EN
  // A load that completes after a refill is counted once, as a miss.
  logic missed;
  always_ff @(posedge clk)
    if (rst) begin
      missed   <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state == IDLE && rd && !hit) missed <= 1'b1;
      else if (ld_hit) missed <= 1'b0;
      if (((ld_hit && !missed) || (wr_done && hit)) && ~&hit_cnt) hit_cnt <= hit_cnt + 1'b1;
      if (((ld_hit && missed) || (wr_done && !hit)) && ~&miss_cnt) miss_cnt <= miss_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench for dcache_ctrl with an SRAM model acking 3 cycles after request.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } txn_t;
  typedef struct { logic hit; logic [31:0] rd; } exp_t;

  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [31:0] mem [logic [31:0]];
  txn_t log_q[$];
  exp_t sb[$];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    int w;
    w = 0;
    bus.sram_ack = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.sram_req || bus.sram_ack) begin
        bus.sram_ack = 1'b0;
        w = 0;
      end else begin
        w++;
        if (w == 3) begin
          bus.sram_ack = 1'b1;
          if (bus.sram_we) mem[bus.sram_addr] = bus.sram_wdata;
          else bus.sram_rdata = mrd(bus.sram_addr);
          log_q.push_back('{bus.sram_we, bus.sram_addr, bus.sram_wdata});
        end
      end
    end
  end

  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d,
                    input logic exp_hit, input string tag);
    exp_t e;
    int lat;
    logic [31:0] got;
    e.hit = exp_hit;
    e.rd  = we ? 32'h0 : mrd(a);
    sb.push_back(e);
    log_q.delete();
    @(negedge clk);
    bus.rd_en = !we;
    bus.wr_en = we;
    bus.addr  = a;
    bus.wdata = d;
    #1;
    lat = 0;
    while (!bus.ready && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    got = bus.rdata;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done"}, 32'(lat < 100), 32'd1);
    if (we) begin
      chk({tag, "_nwr"}, 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
        chk({tag, "_we"}, 32'(log_q[0].we), 32'd1);
        chk({tag, "_waddr"}, log_q[0].a, a & ~32'd3);
        chk({tag, "_wdata"}, log_q[0].d, d);
      end
    end else begin
      chk({tag, "_rdata"}, got, e.rd);
      chk({tag, "_hit"}, 32'(lat == 0), 32'(e.hit));
      chk({tag, "_nrd"}, 32'(log_q.size()), e.hit ? 32'd0 : 32'd2);
      if (!e.hit && log_q.size() == 2) begin
        chk({tag, "_rd0"}, log_q[0].a, a & ~32'd7);
        chk({tag, "_rd1"}, log_q[1].a, (a & ~32'd7) + 32'd4);
        chk({tag, "_rdwe"}, 32'(log_q[0].we | log_q[1].we), 32'd0);
      end
    end
    if (exp_hit) exp_hits++;
    else exp_misses++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    mem[32'h40] = 32'hA;
    mem[32'h44] = 32'hB;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_req", 32'(bus.sram_req), 32'd0);
    chk("rst_we", 32'(bus.sram_we), 32'd0);
    chk("rst_saddr", bus.sram_addr, 32'd0);
    chk("rst_swdata", bus.sram_wdata, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;

    op(1'b0, 32'h40, 32'h0, 1'b0, "cold_ld40");
    op(1'b0, 32'h44, 32'h0, 1'b1, "hit_ld44");
    op(1'b1, 32'h44, 32'h1234, 1'b1, "st_hit44");
    op(1'b0, 32'h44, 32'h0, 1'b1, "ld44_new");
    op(1'b1, 32'h800, 32'h5A5A, 1'b0, "st_miss800");
    op(1'b0, 32'h800, 32'h0, 1'b0, "ld800_miss");
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_a", hit_cnt, 32'(exp_hits));
    chk("miss_cnt_a", miss_cnt, 32'(exp_misses));
`endif

    // Reset after the first ack of a refill.
    @(negedge clk);
    bus.rd_en = 1'b1;
    bus.addr  = 32'h1040;
    #1;
    lat = 0;
    while (!bus.sram_ack && lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("mid_ack_seen", 32'(lat < 100), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus.rd_en = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_ready", 32'(bus.ready), 32'd1);
    chk("mid_req", 32'(bus.sram_req), 32'd0);
    chk("mid_saddr", bus.sram_addr, 32'd0);
    chk("mid_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    op(1'b0, 32'h40, 32'h0, 1'b0, "post_rst_ld40");

    op(1'b0, 32'h000, 32'h0, 1'b0, "repl_ld000");
    op(1'b0, 32'h200, 32'h0, 1'b0, "repl_ld200");
    op(1'b0, 32'h400, 32'h0, 1'b0, "repl_ld400");
    op(1'b0, 32'h200, 32'h0, 1'b1, "repl_hit200");
    op(1'b0, 32'h000, 32'h0, 1'b0, "repl_miss000");
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_b", hit_cnt, 32'(exp_hits));
    chk("miss_cnt_b", miss_cnt, 32'(exp_misses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
